// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Package     : exec_pkg
// Description : Shared types and constants for the execute stage. Holds the
//               divider FSM state encoding, the default datapath width and the
//               matching divider step-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

    localparam int C_DATA_W = 32;
    localparam int C_CNT_W  = $clog2(C_DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Iterative signed restoring divider. It does one quotient bit
//               per cycle on operand magnitudes and applies the sign rules on
//               the last step.
// Ports       : clk, reset      - clock, asynchronous active-high reset
//               start_i         - request a division (sampled in IDLE)
//               hold_i          - keep DONE (and its result) for another cycle
//               dividend_i/divisor_i - signed operands, captured at start
//               busy_o          - stall request (start cycle + BUSY)
//               done_o          - result valid on quotient_o/remainder_o
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import exec_pkg::*;
#(
    parameter int DATA_W = C_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              hold_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o
);

    localparam int CNT_W = $clog2(DATA_W);

    div_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] quo_q;     // dividend bits shift out, quotient bits shift in
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] dvs_q;     // divisor magnitude
    logic              neg_quo_q;
    logic              neg_rem_q;

    logic [DATA_W-1:0] w_dvd_mag;
    logic [DATA_W-1:0] w_dvs_mag;
    logic [DATA_W:0]   w_trial;
    logic              w_fits;
    logic [DATA_W-1:0] w_step_rem;
    logic [DATA_W-1:0] w_step_quo;

    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude.
    assign w_dvd_mag = dividend_i[DATA_W-1] ? (-dividend_i) : dividend_i;
    assign w_dvs_mag = divisor_i[DATA_W-1]  ? (-divisor_i)  : divisor_i;

    // One extra bit keeps the shifted partial remainder (< 2*divisor) exact.
    assign w_trial    = {rem_q, quo_q[DATA_W-1]} - {1'b0, dvs_q};
    assign w_fits     = ~w_trial[DATA_W];
    assign w_step_rem = w_fits ? w_trial[DATA_W-1:0] : {rem_q[DATA_W-2:0], quo_q[DATA_W-1]};
    assign w_step_quo = {quo_q[DATA_W-2:0], w_fits};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        neg_quo_q <= dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1];
                        neg_rem_q <= dividend_i[DATA_W-1];
                        if (divisor_i == '0) begin
                            quo_q   <= '1;
                            rem_q   <= dividend_i;
                            state_q <= ST_DONE;
                        end else begin
                            quo_q   <= w_dvd_mag;
                            rem_q   <= '0;
                            dvs_q   <= w_dvs_mag;
                            cnt_q   <= CNT_W'(DATA_W - 1);
                            state_q <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        quo_q   <= neg_quo_q ? (-w_step_quo) : w_step_quo;
                        rem_q   <= neg_rem_q ? (-w_step_rem) : w_step_rem;
                        state_q <= ST_DONE;
                    end else begin
                        quo_q <= w_step_quo;
                        rem_q <= w_step_rem;
                    end
                end
                ST_DONE: begin
                    if (!hold_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The start cycle stalls too, so the latch keeps the DIV until DONE.
    assign busy_o      = ~reset & (((state_q == ST_IDLE) & start_i) | (state_q == ST_BUSY));
    assign done_o      = (state_q == ST_DONE);
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule
`default_nettype wire

// File: rtl/execute_unit.sv
`default_nettype none
// ============================================================================
// Module      : execute_unit
// Description : Execute stage. Combinational ALU, registered compare flags,
//               branch resolution and an iterative signed DIV/MOD that stalls
//               the decode/execute latch while it works.
// Ports       : clk, reset               - clock, asynchronous active-high reset
//               validE, holdE            - instruction valid, latch held elsewhere
//               PCE, branchTargetE, immxE, op1E, op2E - latched data
//               is*E                     - one-hot ALU op and branch controls
//               aluResultE               - result of the current instruction
//               isBranchTakenE, branchPCE - fetch redirect
//               flagE, flagGT            - registered compare flags
//               stallE                   - hold D/E while the divider is busy
// Revision    : 1.0 - initial release
// ============================================================================
module execute_unit
    import exec_pkg::*;
#(
    parameter int DATA_W = C_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              validE,
    input  logic              holdE,
    input  logic [DATA_W-1:0] PCE,
    input  logic [DATA_W-1:0] branchTargetE,
    input  logic [DATA_W-1:0] immxE,
    input  logic [DATA_W-1:0] op1E,
    input  logic [DATA_W-1:0] op2E,
    input  logic              isAddE,
    input  logic              isSubE,
    input  logic              isCmpE,
    input  logic              isMulE,
    input  logic              isDivE,
    input  logic              isModE,
    input  logic              isLslE,
    input  logic              isLsrE,
    input  logic              isAsrE,
    input  logic              isOrE,
    input  logic              isAndE,
    input  logic              isNotE,
    input  logic              isMovE,
    input  logic              isImmediateE,
    input  logic              isBeqE,
    input  logic              isBgtE,
    input  logic              isUbranchE,
    input  logic              isRetE,
    input  logic              isCallE,
    output logic [DATA_W-1:0] aluResultE,
    output logic              isBranchTakenE,
    output logic [DATA_W-1:0] branchPCE,
    output logic              flagE,
    output logic              flagGT,
    output logic              stallE
);

    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] w_b;
    logic [SH_W-1:0]   w_sh;
    logic [DATA_W-1:0] w_alu;
    logic              w_div_start;
    logic              w_div_busy;
    logic              w_div_done;
    logic [DATA_W-1:0] w_quo;
    logic [DATA_W-1:0] w_rem;
    logic              flag_eq_q;
    logic              flag_gt_q;

    assign w_b  = isImmediateE ? immxE : op2E;
    assign w_sh = w_b[SH_W-1:0];

    always_comb begin
        w_alu = '0;
        if (isAddE)       w_alu = op1E + w_b;
        else if (isSubE)  w_alu = op1E - w_b;
        else if (isMulE)  w_alu = op1E * w_b;   // low half is sign-agnostic
        else if (isLslE)  w_alu = op1E << w_sh;
        else if (isLsrE)  w_alu = op1E >> w_sh;
        else if (isAsrE)  w_alu = DATA_W'($signed(op1E) >>> w_sh);
        else if (isOrE)   w_alu = op1E | w_b;
        else if (isAndE)  w_alu = op1E & w_b;
        else if (isNotE)  w_alu = ~w_b;
        else if (isMovE)  w_alu = w_b;
        else if (isCallE) w_alu = PCE + DATA_W'(4);
    end

    assign w_div_start = validE & (isDivE | isModE);

    seq_divider #(
        .DATA_W (DATA_W)
    ) u_div (
        .clk         (clk),
        .reset       (reset),
        .start_i     (w_div_start),
        .hold_i      (holdE),
        .dividend_i  (op1E),
        .divisor_i   (w_b),
        .busy_o      (w_div_busy),
        .done_o      (w_div_done),
        .quotient_o  (w_quo),
        .remainder_o (w_rem)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_eq_q <= 1'b0;
            flag_gt_q <= 1'b0;
        end else if (validE && isCmpE) begin
            flag_eq_q <= (op1E == w_b);
            flag_gt_q <= ($signed(op1E) > $signed(w_b));
        end
    end

    assign flagE  = flag_eq_q;
    assign flagGT = flag_gt_q;
    assign stallE = w_div_busy;

    assign aluResultE = reset      ? '0 :
                        w_div_done ? (isModE ? w_rem : w_quo) :
                                     w_alu;

    assign isBranchTakenE = ~reset & validE & ~stallE &
                            (isUbranchE | (isBeqE & flag_eq_q) | (isBgtE & flag_gt_q));
    assign branchPCE      = isRetE ? op1E : branchTargetE;

endmodule
`default_nettype wire

// File: tb/tb_execute_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_unit
// Description : Self-checking bench for execute_unit: table of single-cycle
//               ALU vectors, flag/branch sequences and DIV/MOD sequences with
//               expected results queued at issue and compared at completion.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         validE, holdE;
    logic [W-1:0] PCE, branchTargetE, immxE, op1E, op2E;
    logic         isAddE, isSubE, isCmpE, isMulE, isDivE, isModE, isLslE, isLsrE;
    logic         isAsrE, isOrE, isAndE, isNotE, isMovE;
    logic         isImmediateE, isBeqE, isBgtE, isUbranchE, isRetE, isCallE;
    logic [W-1:0] aluResultE, branchPCE;
    logic         isBranchTakenE, flagE, flagGT, stallE;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [W-1:0] exp_q[$];

    typedef enum int {
        OP_ADD, OP_SUB, OP_MUL, OP_LSL, OP_LSR, OP_ASR, OP_OR,
        OP_AND, OP_NOT, OP_MOV, OP_CALL, OP_NONE
    } op_e;

    typedef struct {
        op_e          op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         imm;
        logic [W-1:0] pc;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[14];

    execute_unit #(.DATA_W(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .validE         (validE),
        .holdE          (holdE),
        .PCE            (PCE),
        .branchTargetE  (branchTargetE),
        .immxE          (immxE),
        .op1E           (op1E),
        .op2E           (op2E),
        .isAddE         (isAddE),
        .isSubE         (isSubE),
        .isCmpE         (isCmpE),
        .isMulE         (isMulE),
        .isDivE         (isDivE),
        .isModE         (isModE),
        .isLslE         (isLslE),
        .isLsrE         (isLsrE),
        .isAsrE         (isAsrE),
        .isOrE          (isOrE),
        .isAndE         (isAndE),
        .isNotE         (isNotE),
        .isMovE         (isMovE),
        .isImmediateE   (isImmediateE),
        .isBeqE         (isBeqE),
        .isBgtE         (isBgtE),
        .isUbranchE     (isUbranchE),
        .isRetE         (isRetE),
        .isCallE        (isCallE),
        .aluResultE     (aluResultE),
        .isBranchTakenE (isBranchTakenE),
        .branchPCE      (branchPCE),
        .flagE          (flagE),
        .flagGT         (flagGT),
        .stallE         (stallE)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_ctl();
        validE = 0; holdE = 0;
        PCE = '0; branchTargetE = '0; immxE = '0; op1E = '0; op2E = '0;
        isAddE = 0; isSubE = 0; isCmpE = 0; isMulE = 0; isDivE = 0; isModE = 0;
        isLslE = 0; isLsrE = 0; isAsrE = 0; isOrE = 0; isAndE = 0; isNotE = 0;
        isMovE = 0; isImmediateE = 0; isBeqE = 0; isBgtE = 0; isUbranchE = 0;
        isRetE = 0; isCallE = 0;
    endtask

    task automatic drive_vec(input vec_t v);
        clear_ctl();
        validE       = 1;
        op1E         = v.a;
        PCE          = v.pc;
        isImmediateE = v.imm;
        // The unused operand source carries junk so a wrong mux is visible.
        if (v.imm) begin immxE = v.b; op2E = ~v.b; end
        else       begin op2E = v.b;  immxE = ~v.b; end
        case (v.op)
            OP_ADD:  isAddE  = 1;
            OP_SUB:  isSubE  = 1;
            OP_MUL:  isMulE  = 1;
            OP_LSL:  isLslE  = 1;
            OP_LSR:  isLsrE  = 1;
            OP_ASR:  isAsrE  = 1;
            OP_OR:   isOrE   = 1;
            OP_AND:  isAndE  = 1;
            OP_NOT:  isNotE  = 1;
            OP_MOV:  isMovE  = 1;
            OP_CALL: isCallE = 1;
            default: ;
        endcase
    endtask

    // Issues a DIV/MOD, scrambles the operands once BUSY, and compares the
    // queued expectation and the stall length when stallE drops.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic is_mod,
                          input logic [W-1:0] exp, input int exp_stall, input string name,
                          output int done_cyc);
        int  n;
        bit  seen;
        logic [W-1:0] e;
        n    = 0;
        seen = 0;
        @(posedge clk); #1;
        clear_ctl();
        validE = 1; isDivE = !is_mod; isModE = is_mod; op1E = a; op2E = b;
        exp_q.push_back(exp);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!stallE) begin
                seen = 1;
                break;
            end
            n++;
            @(posedge clk); #1;
            if (n == 1) begin
                op1E = $urandom;
                op2E = $urandom;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: stallE still high after 200 cycles, expected low", name);
        end
        e = exp_q.pop_front();
        check(name, aluResultE, e);
        check({name, "_stall_cycles"}, W'(n), W'(exp_stall));
        done_cyc = cyc;
    endtask

    initial begin
        int d1, d2;

        vecs[0]  = '{OP_ADD,  32'd5,          32'd7,          1'b1, 32'h0,   32'd12};
        vecs[1]  = '{OP_SUB,  32'd3,          32'd5,          1'b0, 32'h0,   32'hFFFF_FFFE};
        vecs[2]  = '{OP_ADD,  32'hFFFF_FFFF,  32'd1,          1'b0, 32'h0,   32'h0};
        vecs[3]  = '{OP_MUL,  32'hFFFF_FFFD,  32'd7,          1'b0, 32'h0,   32'hFFFF_FFEB};
        vecs[4]  = '{OP_MUL,  32'h0001_0000,  32'h0001_0000,  1'b0, 32'h0,   32'h0};
        vecs[5]  = '{OP_LSL,  32'd1,          32'h24,         1'b1, 32'h0,   32'h10};
        vecs[6]  = '{OP_LSR,  32'h8000_0000,  32'd31,         1'b0, 32'h0,   32'h1};
        vecs[7]  = '{OP_ASR,  32'h8000_0000,  32'd4,          1'b0, 32'h0,   32'hF800_0000};
        vecs[8]  = '{OP_OR,   32'hF0,         32'h0F,         1'b0, 32'h0,   32'hFF};
        vecs[9]  = '{OP_AND,  32'hF0F0,       32'hFF00,       1'b0, 32'h0,   32'hF000};
        vecs[10] = '{OP_NOT,  32'h0,          32'h0000_FFFF,  1'b0, 32'h0,   32'hFFFF_0000};
        vecs[11] = '{OP_MOV,  32'd99,         32'h1234,       1'b1, 32'h0,   32'h1234};
        vecs[12] = '{OP_CALL, 32'h0,          32'h0,          1'b0, 32'h100, 32'h104};
        vecs[13] = '{OP_NONE, 32'd5,          32'd7,          1'b0, 32'h0,   32'h0};

        // Reset with a DIV, an ADD and an unconditional branch all requested.
        clear_ctl();
        reset = 1;
        validE = 1; isDivE = 1; isAddE = 1; isUbranchE = 1; op1E = 5; op2E = 7;
        @(negedge clk);
        check("rst_stall",  W'(stallE), 0);
        check("rst_taken",  W'(isBranchTakenE), 0);
        check("rst_alu",    aluResultE, 0);
        check("rst_flagE",  W'(flagE), 0);
        check("rst_flagGT", W'(flagGT), 0);
        @(posedge clk); #1;
        clear_ctl();
        reset = 0;

        // Single-cycle ALU table.
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            drive_vec(vecs[i]);
            exp_q.push_back(vecs[i].exp);
            @(negedge clk);
            check($sformatf("alu_vec%0d", i), aluResultE, exp_q.pop_front());
            check($sformatf("alu_vec%0d_stall", i), W'(stallE), 0);
        end

        // CMP 3,3 then BEQ.
        @(posedge clk); #1;
        clear_ctl(); validE = 1; isCmpE = 1; op1E = 3; op2E = 3;
        @(posedge clk); #1;
        clear_ctl(); validE = 1; isBeqE = 1; branchTargetE = 32'h40;
        @(negedge clk);
        check("cmp_eq_flagE",  W'(flagE), 1);
        check("cmp_eq_flagGT", W'(flagGT), 0);
        check("beq_taken",     W'(isBranchTakenE), 1);
        check("beq_pc",        branchPCE, 32'h40);

        // Signed compare 5 > -2 (immediate operand), then BGT and BEQ.
        @(posedge clk); #1;
        clear_ctl(); validE = 1; isCmpE = 1; op1E = 5; immxE = 32'hFFFF_FFFE; isImmediateE = 1;
        @(posedge clk); #1;
        clear_ctl(); validE = 1; isBgtE = 1; branchTargetE = 32'h80;
        @(negedge clk);
        check("cmp_gt_flagE",  W'(flagE), 0);
        check("cmp_gt_flagGT", W'(flagGT), 1);
        check("bgt_taken",     W'(isBranchTakenE), 1);
        check("bgt_pc",        branchPCE, 32'h80);
        @(posedge clk); #1;
        clear_ctl(); validE = 1; isBeqE = 1; branchTargetE = 32'h80;
        @(negedge clk);
        check("beq_not_taken", W'(isBranchTakenE), 0);

        // A bubble CMP must not touch the flags.
        @(posedge clk); #1;
        clear_ctl(); validE = 0; isCmpE = 1; op1E = 7; op2E = 7;
        @(posedge clk); #1;
        clear_ctl();
        @(negedge clk);
        check("bubble_cmp_flagE",  W'(flagE), 0);
        check("bubble_cmp_flagGT", W'(flagGT), 1);

        // RET redirects to op1; a bubble branch is never taken.
        @(posedge clk); #1;
        clear_ctl(); validE = 1; isUbranchE = 1; isRetE = 1; op1E = 32'h200; branchTargetE = 32'h300;
        @(negedge clk);
        check("ret_taken", W'(isBranchTakenE), 1);
        check("ret_pc",    branchPCE, 32'h200);
        @(posedge clk); #1;
        validE = 0;
        @(negedge clk);
        check("bubble_branch", W'(isBranchTakenE), 0);

        // DIV/MOD sequences.
        do_div(32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFD, 33, "div_m7_2", d1);
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 33, "mod_m7_2", d1);
        do_div(32'd9, 32'd0, 1'b0, 32'hFFFF_FFFF, 1, "div_9_0", d1);
        do_div(32'd9, 32'd0, 1'b1, 32'd9,         1, "mod_9_0", d1);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 33, "div_min_m1", d1);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0,         33, "mod_min_m1", d1);

        // Hold in DONE for three cycles: result stays, no restart.
        do_div(32'd50, 32'hFFFF_FFF9, 1'b0, 32'hFFFF_FFF9, 33, "div_50_m7", d1);
        holdE = 1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("hold%0d_stall", k), W'(stallE), 0);
            check($sformatf("hold%0d_alu", k), aluResultE, 32'hFFFF_FFF9);
        end
        holdE = 0;

        // Back-to-back divisions.
        do_div(32'd20, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFA, 33, "b2b_div_20_m3", d1);
        do_div(32'hFFFF_FFEC, 32'd3,  1'b1, 32'hFFFF_FFFE, 33, "b2b_mod_m20_3", d2);
        check("b2b_gap", W'(d2 - d1), 34);

        // Reset in the middle of a division.
        @(posedge clk); #1;
        clear_ctl(); validE = 1; isCmpE = 1; op1E = 3; op2E = 3;
        @(posedge clk); #1;
        clear_ctl(); validE = 1; isDivE = 1; op1E = 100; op2E = 7;
        repeat (10) @(posedge clk);
        #1;
        check("busy10_stall", W'(stallE), 1);
        reset = 1;
        #1;
        check("midrst_stall", W'(stallE), 0);
        check("midrst_alu",   aluResultE, 0);
        check("midrst_flagE", W'(flagE), 0);
        @(posedge clk); #1;
        clear_ctl();
        reset = 0;
        @(negedge clk);
        check("postrst_stall", W'(stallE), 0);
        do_div(32'd100, 32'd10, 1'b0, 32'd10, 33, "div_100_10", d1);

        @(posedge clk); #1;
        clear_ctl();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
